// File: rtl/spi_flash_byte_programmer.sv
// spi_flash_byte_programmer
//   Programs one byte into the SPI boot flash on a 6809 write into the ROM
//   window: WREN (0x06), PAGE PROGRAM (0x02 + addr24 + data), then RDSR
//   (0x05) status polling until WIP clears or POLL_LIMIT bytes have been read.
//   SPI mode 0, MSB first, SCK = clk / (2*CLK_DIV).
//   Optional macro SPI_PROG_SECTOR_ERASE_EN: when the latched flash address is
//   4KB aligned, WREN + SECTOR ERASE (0x20 + addr24) + poll run first.
// Ports:
//   clk, reset (async, active low)
//   i_start/i_addr/i_data : one-cycle program request, accepted only when idle
//   i_SPI_MISO            : flash serial data out
//   o_SPI_CLK/o_SPI_MOSI/o_SPI_CS : flash pins (all registered)
//   o_bus_req/o_busy      : high while a program sequence is running
//   o_done                : one-cycle success pulse
//   o_error               : sticky poll timeout, cleared by the next start
module spi_flash_byte_programmer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int unsigned CS_GAP     = 4,
  parameter logic [19:0] POLL_LIMIT = 20'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [11:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_SPI_MISO,
  output logic        o_SPI_CLK,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS,
  output logic        o_bus_req,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_RLD = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_RLD = GW'(CS_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_PROG, S_POLL, S_GAP, S_DONE, S_ERR
`ifdef SPI_PROG_SECTOR_ERASE_EN
    , S_EWREN, S_ERASE, S_EPOLL
`endif
  } st_t;

  // Frame sub-phase: CS falls (SETUP), first bit presented (LEAD),
  // bits clocked (BITS), CS held one cycle after the last falling edge (HOLD).
  typedef enum logic [1:0] {PH_SETUP, PH_LEAD, PH_BITS, PH_HOLD} ph_t;

  st_t         state_q, nxt_q, first_st;
  ph_t         ph_q;
  logic [39:0] sh_q;
  logic [5:0]  nb_q;
  logic [DW-1:0] div_q;
  logic [GW-1:0] gap_q;
  logic [19:0] pcnt_q;
  logic        pst_q, miso_q, perr_q;
  logic [23:0] addr_q, start_addr;
  logic [7:0]  data_q;
  logic        cs_q, sck_q, mosi_q, busy_q, done_q, err_q;
  logic        is_poll;

  // {shift contents, bit count} for the frame issued in state s
  function automatic logic [45:0] frame_of(st_t s, logic [23:0] a, logic [7:0] d);
    case (s)
      S_PROG:  frame_of = {8'h02, a, d, 6'd40};
      S_POLL:  frame_of = {8'h05, 32'h0, 6'd8};
`ifdef SPI_PROG_SECTOR_ERASE_EN
      S_ERASE: frame_of = {8'h20, a, 8'h00, 6'd32};
      S_EPOLL: frame_of = {8'h05, 32'h0, 6'd8};
`endif
      default: frame_of = {8'h06, 32'h0, 6'd8};
    endcase
  endfunction

  always_comb begin
    start_addr = FLASH_BASE + {12'h000, i_addr};
    first_st   = S_WREN;
    is_poll    = (state_q == S_POLL);
`ifdef SPI_PROG_SECTOR_ERASE_EN
    if (start_addr[11:0] == 12'h000) first_st = S_EWREN;
    is_poll = (state_q == S_POLL) || (state_q == S_EPOLL);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;  nxt_q  <= S_IDLE;  ph_q   <= PH_SETUP;
      sh_q    <= '0;      nb_q   <= '0;      div_q  <= '0;
      gap_q   <= '0;      pcnt_q <= '0;      pst_q  <= 1'b0;
      miso_q  <= 1'b0;    perr_q <= 1'b0;    addr_q <= '0;
      data_q  <= '0;      cs_q   <= 1'b1;    sck_q  <= 1'b0;
      mosi_q  <= 1'b0;    busy_q <= 1'b0;    done_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (i_start) begin
          addr_q  <= start_addr;
          data_q  <= i_data;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= first_st;
          ph_q    <= PH_SETUP;
          {sh_q, nb_q} <= frame_of(first_st, start_addr, i_data);
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= nxt_q;
            ph_q    <= PH_SETUP;
            pst_q   <= 1'b0;
            pcnt_q  <= '0;
            {sh_q, nb_q} <= frame_of(nxt_q, addr_q, data_q);
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          case (ph_q)
            PH_SETUP: begin
              cs_q <= 1'b0;
              ph_q <= PH_LEAD;
            end
            PH_LEAD: begin
              mosi_q <= sh_q[39];
              div_q  <= DIV_RLD;
              ph_q   <= PH_BITS;
            end
            PH_BITS: begin
              if (div_q != '0) begin
                div_q <= div_q - 1'b1;
              end else begin
                div_q <= DIV_RLD;
                if (!sck_q) begin
                  sck_q  <= 1'b1;
                  miso_q <= i_SPI_MISO;
                end else begin
                  sck_q <= 1'b0;
                  if (nb_q != 6'd1) begin
                    sh_q   <= {sh_q[38:0], 1'b0};
                    nb_q   <= nb_q - 6'd1;
                    mosi_q <= sh_q[38];
                  end else if (is_poll && !pst_q) begin
                    // RDSR opcode sent; status bytes follow with CS still low
                    pst_q  <= 1'b1;
                    sh_q   <= '0;
                    nb_q   <= 6'd8;
                    mosi_q <= 1'b0;
                  end else if (is_poll && miso_q && (pcnt_q + 20'd1 < POLL_LIMIT)) begin
                    // WIP still set and budget left: clock another status byte
                    pcnt_q <= pcnt_q + 20'd1;
                    sh_q   <= '0;
                    nb_q   <= 6'd8;
                    mosi_q <= 1'b0;
                  end else begin
                    ph_q   <= PH_HOLD;
                    mosi_q <= 1'b0;
                    perr_q <= is_poll && miso_q;
                  end
                end
              end
            end
            default: begin // PH_HOLD
              cs_q    <= 1'b1;
              gap_q   <= GAP_RLD;
              state_q <= S_GAP;
              case (state_q)
                S_WREN:  nxt_q <= S_PROG;
                S_PROG:  nxt_q <= S_POLL;
                S_POLL:  state_q <= perr_q ? S_ERR : S_DONE;
`ifdef SPI_PROG_SECTOR_ERASE_EN
                S_EWREN: nxt_q <= S_ERASE;
                S_ERASE: nxt_q <= S_EPOLL;
                S_EPOLL: if (perr_q) state_q <= S_ERR; else nxt_q <= S_WREN;
`endif
                default: nxt_q <= S_IDLE;
              endcase
            end
          endcase
        end
      endcase
    end
  end

  assign o_SPI_CLK  = sck_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS   = cs_q;
  assign o_bus_req  = busy_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = err_q;
endmodule

// File: tb/tb_spi_flash_byte_programmer.sv
// Bench for spi_flash_byte_programmer: a flash model watches the SPI pins,
// records every CS-low session as bytes and answers RDSR with a scripted
// status stream; expected sessions come from a command-level model.
module tb_spi_flash_byte_programmer;
  localparam logic [23:0] BASE = 24'h000000;
  localparam int PL = 4;
`ifdef SPI_PROG_SECTOR_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, i_start = 1'b0, i_SPI_MISO = 1'b0;
  logic [11:0] i_addr = '0;
  logic [7:0]  i_data = '0;
  logic o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_bus_req, o_busy, o_done, o_error;

  spi_flash_byte_programmer #(.CLK_DIV(2), .FLASH_BASE(BASE), .CS_GAP(4),
                              .POLL_LIMIT(20'(PL))) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_addr(i_addr),
    .i_data(i_data), .i_SPI_MISO(i_SPI_MISO), .o_SPI_CLK(o_SPI_CLK),
    .o_SPI_MOSI(o_SPI_MOSI), .o_SPI_CS(o_SPI_CS), .o_bus_req(o_bus_req),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- flash model / session log ----------------
  logic [7:0] lb[$];          // all captured bytes
  int lstart[$], llen[$];     // per-session start index and byte count
  int bitk = 0, cfg_busy = 0, done_cnt = 0, viol = 0, hirun = 0;
  logic [7:0] cur = '0;
  logic p_cs = 1'b1, p_sck = 1'b0;

  // status byte j of a poll session: cfg_busy bytes with WIP set, then 0x00;
  // cfg_busy >= 100 means MISO stuck high
  function automatic logic miso_bit(int k);
    int j; logic [7:0] s;
    if (k < 8) return 1'b0;
    if (lb[lstart[$]] != 8'h05) return 1'b0;
    j = (k - 8) / 8;
    s = (j < cfg_busy) ? ((cfg_busy >= 100) ? 8'hFF : 8'h01) : 8'h00;
    return s[7 - (k % 8)];
  endfunction

  always @(negedge clk) begin
    if (o_SPI_CS && (o_SPI_CLK || o_SPI_MOSI)) viol++;
    if (o_done) begin
      done_cnt++;
      if (o_busy || o_bus_req) viol++;
    end
    if (p_cs && !o_SPI_CS) begin
      if (o_busy && hirun < 4) viol++;
      bitk = 0; cur = '0;
      lstart.push_back(lb.size());
      i_SPI_MISO = miso_bit(0);
    end else if (!o_SPI_CS) begin
      if (!p_sck && o_SPI_CLK) begin
        cur = {cur[6:0], o_SPI_MOSI};
        bitk++;
        if (bitk % 8 == 0) lb.push_back(cur);
      end
      if (p_sck && !o_SPI_CLK) i_SPI_MISO = miso_bit(bitk);
    end
    if (!p_cs && o_SPI_CS) begin
      llen.push_back(lb.size() - lstart[$]);
      i_SPI_MISO = 1'b0;
    end
    hirun = o_SPI_CS ? hirun + 1 : 0;
    p_cs = o_SPI_CS; p_sck = o_SPI_CLK;
  end

  // ---------------- command-level reference model ----------------
  logic [7:0] exp_b[$];
  int exp_len[$];
  bit exp_e;

  task automatic build_exp(input logic [11:0] a, input logic [7:0] d, input int bn);
    logic [23:0] fa; int ns;
    fa = BASE + {12'h0, a};
    exp_e = (bn >= PL);
    ns = exp_e ? PL : bn + 1;
    exp_b.delete(); exp_len.delete();
    if (ERASE && fa[11:0] == 12'h0) begin
      exp_b.push_back(8'h06); exp_len.push_back(1);
      exp_b.push_back(8'h20); exp_b.push_back(fa[23:16]);
      exp_b.push_back(fa[15:8]); exp_b.push_back(fa[7:0]); exp_len.push_back(4);
      exp_b.push_back(8'h05);
      for (int i = 0; i < ns; i++) exp_b.push_back(8'h00);
      exp_len.push_back(ns + 1);
      if (exp_e) return;
    end
    exp_b.push_back(8'h06); exp_len.push_back(1);
    exp_b.push_back(8'h02); exp_b.push_back(fa[23:16]); exp_b.push_back(fa[15:8]);
    exp_b.push_back(fa[7:0]); exp_b.push_back(d); exp_len.push_back(5);
    exp_b.push_back(8'h05);
    for (int i = 0; i < ns; i++) exp_b.push_back(8'h00);
    exp_len.push_back(ns + 1);
  endtask

  task automatic start_txn(input string nm, input logic [11:0] a, input logic [7:0] d,
                           input int bn);
    build_exp(a, d, bn);
    cfg_busy = bn;
    lb.delete(); lstart.delete(); llen.delete(); done_cnt = 0;
    @(negedge clk); i_start = 1'b1; i_addr = a; i_data = d;
    @(negedge clk); i_start = 1'b0;
    check({nm, " busy/bus_req/err after accept"}, {o_busy, o_bus_req, o_error}, 3'b110);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (o_busy && n < 5000) begin @(negedge clk); n++; end
    if (o_busy) check({nm, " completion timeout"}, 1, 0);
  endtask

  task automatic finish_txn(input string nm);
    int bad;
    wait_idle(nm);
    repeat (3) @(negedge clk);
    check({nm, " session count"}, llen.size(), exp_len.size());
    bad = -1;
    for (int i = 0; i < exp_len.size(); i++)
      if (bad < 0 && (i >= llen.size() || llen[i] != exp_len[i])) bad = i;
    check({nm, " first bad session length idx"}, bad, -1);
    bad = -1;
    for (int i = 0; i < exp_b.size(); i++)
      if (bad < 0 && (i >= lb.size() || lb[i] != exp_b[i])) bad = i;
    check({nm, " first bad byte idx"}, bad, -1);
    check({nm, " error flag"}, o_error, exp_e);
    check({nm, " done pulses"}, done_cnt, exp_e ? 0 : 1);
  endtask

  typedef struct {
    logic [11:0] addr; logic [7:0] data; int busy_n; int exp_nstat; int exp_err;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nz;
    logic [11:0] ra;
    vecs[0] = '{12'h123, 8'hA5, 2,   3, 0};
    vecs[1] = '{12'hFFF, 8'h00, 0,   1, 0};
    vecs[2] = '{12'h800, 8'hFF, 3,   4, 0};
    vecs[3] = '{12'h456, 8'h3C, 100, 4, 1};   // MISO stuck high -> timeout
    vecs[4] = '{12'h001, 8'h80, 1,   2, 0};   // start after error clears it

    repeat (5) @(negedge clk);
    check("reset outputs {cs,sck,mosi,busy,breq,done,err}",
          {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI, o_busy, o_bus_req, o_done, o_error}, 7'b1000000);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle outputs after release",
          {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI, o_busy, o_bus_req, o_done, o_error}, 7'b1000000);

    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      start_txn(nm, vecs[v].addr, vecs[v].data, vecs[v].busy_n);
      finish_txn(nm);
      check({nm, " table status bytes"}, (llen.size() > 0) ? llen[$] - 1 : -1, vecs[v].exp_nstat);
      check({nm, " table error"}, o_error, vecs[v].exp_err);
    end

    // second start during PROG frame is dropped
    start_txn("busyrej", 12'h123, 8'hA5, 0);
    n = 0;
    while (!(lstart.size() == 2 && !o_SPI_CS && bitk >= 12) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("busyrej reached PROG frame", (n < 3000) ? 1 : 0, 1);
    i_start = 1'b1; i_addr = 12'h200; i_data = 8'h5A;
    @(negedge clk); i_start = 1'b0;
    finish_txn("busyrej");
    repeat (100) @(negedge clk);
    check("busyrej no further sessions", llen.size(), exp_len.size());

    // async reset in the middle of PROG
    start_txn("rstmid", 12'h321, 8'hC3, 0);
    n = 0;
    while (!(lstart.size() == 2 && !o_SPI_CS && bitk >= 20) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("rstmid reached PROG bit 20", (n < 3000) ? 1 : 0, 1);
    #2 reset = 1'b0;
    #1 check("rstmid cs/sck immediate", {o_SPI_CS, o_SPI_CLK}, 2'b10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid idle after reset", {o_busy, o_bus_req, o_SPI_CS}, 3'b001);
    start_txn("rstmid_new", 12'h0AB, 8'h11, 0);
    finish_txn("rstmid_new");

    // aligned address: erase sequence only with the feature macro
    start_txn("erase0", 12'h000, 8'h77, 1);
    finish_txn("erase0");
    nz = 0;
    for (int i = 0; i < lstart.size(); i++) if (lb[lstart[i]] == 8'h20) nz++;
    check("erase0 0x20 frame count", nz, ERASE ? 1 : 0);

    // randomized transactions against the model
    for (int r = 0; r < 20; r++) begin
      ra = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
      start_txn($sformatf("rnd%0d", r), ra, 8'($urandom), $urandom_range(0, 5));
      finish_txn($sformatf("rnd%0d", r));
    end

    check("pin safety / cs gap / done timing violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
